traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Phase sequencer and light driver on the consumer side of the highway (HW) and country-road (CR) countdown timers. Tracks the junction phase from the timers' one-cycle `*_time_out` pulses and the road sensor, and drives both roads' red/yellow/green lamps. Also drives two-digit BCD countdown displays. Cross-checks that the two timers stay phase-aligned, and runs a watchdog that forces a flashing-yellow fault mode if either check fails.

## Interface
- `WDOG_CYCLES`, 1024 — max clk cycles between consecutive timeout pulses (either timer) before fault.
- `FLASH_CYCLES`, 64 — half-period, in clk cycles, of the yellow flash in FAULT.
- `clk` in 1 — single clock; all logic rising-edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `sensor` in 1 — CR vehicle sensor, the same signal the timers see.
- `hw_time_out` in 1 — HW timer phase-end pulse, one cycle wide.
- `cr_time_out` in 1 — CR timer phase-end pulse, one cycle wide.
- `hw_time` in 7 — HW remaining ticks, unsigned.
- `cr_time` in 7 — CR remaining ticks, unsigned.
- `hw_light` out 3 — {red, yellow, green}, one-hot except in FAULT.
- `cr_light` out 3 — {red, yellow, green}.
- `fault` out 1 — high while in FAULT.
- `sync_err` out 1 — sticky; set when the timers are misaligned.
- `hw_disp` out 8 — {tens, ones} BCD of `hw_time`.
- `cr_disp` out 8 — {tens, ones} BCD of `cr_time`.

## Operation
- States: HG_CR (HW green, CR red), HY_CR (HW yellow, CR red), HR_CG (HW red, CR green), HR_CY (HW red, CR yellow), FAULT.
- `sensor_d` is `sensor` registered once, so it holds the value the timers used at their decision edge.
- HG_CR: on `hw_time_out` with `sensor_d`=1, go to HY_CR. With `sensor_d`=0, stay (the timers reload their long period).
- HY_CR to HR_CG on `hw_time_out`.
- HR_CG to HR_CY on `cr_time_out` only. A `hw_time_out` here is a sync error.
- HR_CY to HG_CR on `hw_time_out`.
- Alignment rule for HG_CR, HY_CR and HR_CY: `hw_time_out` and `cr_time_out` must assert in the same cycle. A lone pulse of either kind sets `sync_err` and enters FAULT.
- Watchdog:
  - counter clears on any timeout pulse;
  - on reaching `WDOG_CYCLES`, enters FAULT;
  - saturates and does not wrap.
- FAULT:
  - `hw_light`=`cr_light`={0, flash, 0};
  - flash toggles every `FLASH_CYCLES` and starts at 1;
  - `fault`=1;
  - exits only by reset;
  - further pulses are ignored.
- Lamp encodings:
  - HG_CR: hw 001, cr 100.
  - HY_CR: hw 010, cr 100.
  - HR_CG: hw 100, cr 001.
  - HR_CY: hw 100, cr 010.
- Display conversion:
  - `*_time` values 0–99 convert to BCD;
  - values of 100–127 saturate to 8'h99.

## Timing
- Reset values:
  - state HG_CR, so `hw_light`=3'b001 and `cr_light`=3'b100;
  - `fault`=0, `sync_err`=0;
  - `hw_disp`=`cr_disp`=8'h00;
  - watchdog counter 0, flash phase 1.
- Lamps are registered: a pulse sampled at edge k changes the lamps after edge k.
- Displays are registered with 1-cycle latency from `*_time`.
- Reset asserted mid-phase or in FAULT returns all outputs to reset values immediately (asynchronously). The first phase after release is HG_CR.
- Entering FAULT takes effect in the same cycle as the triggering pulse or watchdog expiry. `sync_err` is set on that same edge.

## Configuration
- `TL_BCD_DISPLAY_EN`:
  - Defined: instantiates the BCD converter and drives `hw_disp`/`cr_disp` as above.
  - Undefined: converter absent; `hw_disp` and `cr_disp` are tied to 8'h00. Sequencing, watchdog and fault behaviour are unchanged.

## Structure
- Package `tl_pkg` holds:
  - phase enum;
  - lamp encodings (`LAMP_RED`, `LAMP_YEL`, `LAMP_GRN`, `LAMP_OFF`);
  - timer constants T=59 and t=9, shared with the timers.
- One sub-module, `tl_bin2bcd`: a combinational 7-bit-to-two-digit BCD converter with saturation, instantiated twice under `TL_BCD_DISPLAY_EN`.

## Test plan
- Reset, then `sensor`=0 with simultaneous pulses every 660 clk → stays HG_CR (hw 001, cr 100); `sync_err`=0.
- `sensor`=1 held, then simultaneous pulse → HY_CR. Next simultaneous pulse → HR_CG. Lone `cr_time_out` → HR_CY. Simultaneous pulse → HG_CR.
- In HY_CR, lone `hw_time_out` → `sync_err`=1, `fault`=1, both roads yellow flashing with a 64-cycle half-period. Later pulses are ignored.
- No pulses for 1024 clk → `fault`=1 with `sync_err`=0. Pulses every 1023 clk → no fault.
- `hw_time`=7'd59 → `hw_disp`=8'h59 one cycle later. `hw_time`=7'd120 → `hw_disp`=8'h99.
- Assert `rst_n` low for 3 cycles while in FAULT → `hw_light`=001, `cr_light`=100, `fault`=0, `sync_err`=0, displays 00.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared phase, lamp and timer definitions for the junction controller and its timers.
package tl_pkg;

    typedef enum logic [2:0] {
        PH_HG_CR = 3'd0,
        PH_HY_CR = 3'd1,
        PH_HR_CG = 3'd2,
        PH_HR_CY = 3'd3,
        PH_FAULT = 3'd4
    } tl_phase_e;

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Long (T) and short (t) timer periods, kept here so the timers and controller agree
    localparam int unsigned TL_T_LONG  = 59;
    localparam int unsigned TL_T_SHORT = 9;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the HW/CR countdown timers (master) and the light controller (slave).
interface traffic_light_ctrl_if;
    logic       sensor;
    logic       hw_time_out;
    logic       cr_time_out;
    logic [6:0] hw_time;
    logic [6:0] cr_time;
    logic [2:0] hw_light;
    logic [2:0] cr_light;
    logic       fault;
    logic       sync_err;
    logic [7:0] hw_disp;
    logic [7:0] cr_disp;

    modport master (
        output sensor, hw_time_out, cr_time_out, hw_time, cr_time,
        input  hw_light, cr_light, fault, sync_err, hw_disp, cr_disp
    );

    modport slave (
        input  sensor, hw_time_out, cr_time_out, hw_time, cr_time,
        output hw_light, cr_light, fault, sync_err, hw_disp, cr_disp
    );
endinterface

// File: rtl/tl_bin2bcd.sv
// Combinational 7-bit binary to two-digit BCD; inputs above 99 saturate to 8'h99.
module tl_bin2bcd (
    input  logic [6:0] i_bin,
    output logic [7:0] o_bcd
);
    logic [3:0] w_tens;
    logic [3:0] w_ones;

    always_comb begin
        w_tens = 4'(i_bin / 7'd10);
        w_ones = 4'(i_bin % 7'd10);
        if (i_bin > 7'd99) begin
            o_bcd = 8'h99;
        end else begin
            o_bcd = {w_tens, w_ones};
        end
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// Junction phase sequencer, lamp driver, timer alignment checker and watchdog.
// Optional BCD countdown displays are built when TL_BCD_DISPLAY_EN is defined.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES  = 1024,
    parameter int unsigned FLASH_CYCLES = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    traffic_light_ctrl_if.slave bus
);
    localparam int WDOG_W  = $clog2(WDOG_CYCLES + 1);
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

    tl_phase_e          r_state;
    tl_phase_e          w_state_nxt;
    logic               r_sensor_d;
    logic               r_sync_err;
    logic [WDOG_W-1:0]  r_wdog;
    logic               r_flash;
    logic [FLASH_W-1:0] r_flash_cnt;
    logic               w_pulse;
    logic               w_both;
    logic               w_sync_set;
    logic               w_wdog_expire;
    logic [2:0]         w_hw_light;
    logic [2:0]         w_cr_light;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PH_HG_CR;
            r_sensor_d  <= 1'b0;
            r_sync_err  <= 1'b0;
            r_wdog      <= '0;
            r_flash     <= 1'b1;
            r_flash_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sensor_d <= bus.sensor;
            if (w_sync_set) begin
                r_sync_err <= 1'b1;
            end
            if (w_pulse) begin
                r_wdog <= '0;
            end else if (r_wdog != WDOG_W'(WDOG_CYCLES)) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
            // Flash phase only runs inside FAULT, so it always opens with the lamp lit
            if (r_state == PH_FAULT) begin
                if (r_flash_cnt == FLASH_W'(FLASH_CYCLES - 1)) begin
                    r_flash_cnt <= '0;
                    r_flash     <= ~r_flash;
                end else begin
                    r_flash_cnt <= r_flash_cnt + FLASH_W'(1);
                end
            end else begin
                r_flash_cnt <= '0;
                r_flash     <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sync_set    = 1'b0;
        w_pulse       = bus.hw_time_out | bus.cr_time_out;
        w_both        = bus.hw_time_out & bus.cr_time_out;
        w_wdog_expire = !w_pulse && (r_wdog == WDOG_W'(WDOG_CYCLES - 1));
        w_hw_light    = LAMP_OFF;
        w_cr_light    = LAMP_OFF;

        unique case (r_state)
            PH_HG_CR: begin
                w_hw_light = LAMP_GRN;
                w_cr_light = LAMP_RED;
                if (w_both) begin
                    if (r_sensor_d) w_state_nxt = PH_HY_CR;
                end else if (w_pulse) begin
                    w_sync_set = 1'b1;
                end
            end
            PH_HY_CR: begin
                w_hw_light = LAMP_YEL;
                w_cr_light = LAMP_RED;
                if (w_both)       w_state_nxt = PH_HR_CG;
                else if (w_pulse) w_sync_set  = 1'b1;
            end
            PH_HR_CG: begin
                w_hw_light = LAMP_RED;
                w_cr_light = LAMP_GRN;
                if (bus.hw_time_out)      w_sync_set  = 1'b1;
                else if (bus.cr_time_out) w_state_nxt = PH_HR_CY;
            end
            PH_HR_CY: begin
                w_hw_light = LAMP_RED;
                w_cr_light = LAMP_YEL;
                if (w_both)       w_state_nxt = PH_HG_CR;
                else if (w_pulse) w_sync_set  = 1'b1;
            end
            PH_FAULT: begin
                w_hw_light = {1'b0, r_flash, 1'b0};
                w_cr_light = {1'b0, r_flash, 1'b0};
            end
            default: begin
                w_state_nxt = PH_FAULT;
            end
        endcase

        if (r_state != PH_FAULT && (w_sync_set || w_wdog_expire)) begin
            w_state_nxt = PH_FAULT;
        end
    end

    assign bus.hw_light = w_hw_light;
    assign bus.cr_light = w_cr_light;
    assign bus.fault    = (r_state == PH_FAULT);
    assign bus.sync_err = r_sync_err;

`ifdef TL_BCD_DISPLAY_EN
    logic [7:0] w_hw_bcd;
    logic [7:0] w_cr_bcd;
    logic [7:0] r_hw_disp;
    logic [7:0] r_cr_disp;

    tl_bin2bcd u_hw_bcd (.i_bin(bus.hw_time), .o_bcd(w_hw_bcd));
    tl_bin2bcd u_cr_bcd (.i_bin(bus.cr_time), .o_bcd(w_cr_bcd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hw_disp <= 8'h00;
            r_cr_disp <= 8'h00;
        end else begin
            r_hw_disp <= w_hw_bcd;
            r_cr_disp <= w_cr_bcd;
        end
    end

    assign bus.hw_disp = r_hw_disp;
    assign bus.cr_disp = r_cr_disp;
`else
    logic w_unused_time;
    assign w_unused_time = ^{bus.hw_time, bus.cr_time};
    assign bus.hw_disp   = 8'h00;
    assign bus.cr_disp   = 8'h00;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl: randomized timer traffic checked against a junction model.
module tb_traffic_light_ctrl;
    localparam int WDOG  = 1024;
    localparam int FLASH = 64;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(
        .WDOG_CYCLES (WDOG),
        .FLASH_CYCLES(FLASH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Junction model: phase index 0..3 walks HG_CR, HY_CR, HR_CG, HR_CY
    logic [2:0] hwLamp [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] crLamp [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
    int         mPhase;
    bit         mFault;
    bit         mSync;
    int         mIdle;
    int         mFaultAge;
    bit         mPrevSensor;
    logic [7:0] mHwDisp;
    logic [7:0] mCrDisp;

    function automatic logic [7:0] toBcd(input int v);
        if (v > 99) return 8'h99;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic modelReset();
        mPhase      = 0;
        mFault      = 0;
        mSync       = 0;
        mIdle       = 0;
        mFaultAge   = 0;
        mPrevSensor = 0;
        mHwDisp     = 8'h00;
        mCrDisp     = 8'h00;
    endtask

    task automatic modelStep(input bit hto, input bit cto, input bit sen,
                             input logic [6:0] ht, input logic [6:0] ct);
        bit pulse;
        bit bad;
        pulse = hto | cto;
        bad   = 0;
        if (mFault) begin
            mFaultAge++;
        end else begin
            if (mPhase == 2) begin
                bad = hto;
                if (!hto && cto) mPhase = 3;
            end else if (hto && cto) begin
                if (mPhase != 0 || mPrevSensor) mPhase = (mPhase + 1) % 4;
            end else begin
                bad = pulse;
            end
            mIdle = pulse ? 0 : mIdle + 1;
            if (bad) begin
                mSync     = 1;
                mFault    = 1;
                mFaultAge = 0;
            end else if (mIdle >= WDOG) begin
                mFault    = 1;
                mFaultAge = 0;
            end
        end
        mPrevSensor = sen;
`ifdef TL_BCD_DISPLAY_EN
        mHwDisp = toBcd(int'(ht));
        mCrDisp = toBcd(int'(ct));
`else
        mHwDisp = (ht == ct) ? 8'h00 : 8'h00;
        mCrDisp = 8'h00;
`endif
    endtask

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] expHw;
        logic [2:0] expCr;
        bit         flash;
        flash = ((mFaultAge / FLASH) % 2) == 0;
        expHw = mFault ? {1'b0, flash, 1'b0} : hwLamp[mPhase];
        expCr = mFault ? {1'b0, flash, 1'b0} : crLamp[mPhase];
        checkOne("hw_light", {5'b0, bus.hw_light}, {5'b0, expHw});
        checkOne("cr_light", {5'b0, bus.cr_light}, {5'b0, expCr});
        checkOne("fault", {7'b0, bus.fault}, {7'b0, mFault});
        checkOne("sync_err", {7'b0, bus.sync_err}, {7'b0, mSync});
        checkOne("hw_disp", bus.hw_disp, mHwDisp);
        checkOne("cr_disp", bus.cr_disp, mCrDisp);
    endtask

    task automatic applyStimulus(input bit hto, input bit cto, input bit sen,
                                 input logic [6:0] ht, input logic [6:0] ct);
        bus.hw_time_out = hto;
        bus.cr_time_out = cto;
        bus.sensor      = sen;
        bus.hw_time     = ht;
        bus.cr_time     = ct;
        @(posedge clk);
        modelStep(hto, cto, sen, ht, ct);
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(input int n, input bit sen);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, sen, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        end
    endtask

    task automatic pulse(input bit hto, input bit cto, input bit sen);
        applyStimulus(hto, cto, sen, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
    endtask

    // Reset is dropped between edges so the outputs must react without a clock
    task automatic doReset(input int cycles);
        @(negedge clk);
        bus.hw_time_out = 1'b0;
        bus.cr_time_out = 1'b0;
        bus.sensor      = 1'b0;
        rst_n           = 1'b0;
        modelReset();
        #1;
        checkOutput();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        rst_n           = 1'b1;
        bus.sensor      = 1'b0;
        bus.hw_time_out = 1'b0;
        bus.cr_time_out = 1'b0;
        bus.hw_time     = 7'd0;
        bus.cr_time     = 7'd0;
        modelReset();

        $display("[TB] reset and idle HG_CR with sensor low");
        doReset(3);
        for (int k = 0; k < 3; k++) begin
            idleCycles(659, 1'b0);
            pulse(1'b1, 1'b1, 1'b0);
        end

        $display("[TB] directed full cycle with sensor high");
        idleCycles(5, 1'b1);
        pulse(1'b1, 1'b1, 1'b1);
        idleCycles(9, 1'b1);
        pulse(1'b1, 1'b1, 1'b1);
        idleCycles(20, 1'b1);
        pulse(1'b0, 1'b1, 1'b1);
        idleCycles(9, 1'b1);
        pulse(1'b1, 1'b1, 1'b1);

        $display("[TB] randomized legal phase traffic");
        for (int k = 0; k < 40; k++) begin
            bit sen;
            sen = 1'($urandom_range(0, 1));
            idleCycles(int'($urandom_range(3, 60)), sen);
            if (mPhase == 2) pulse(1'b0, 1'b1, sen);
            else             pulse(1'b1, 1'b1, sen);
        end

        $display("[TB] misaligned pulse in HY_CR");
        for (int k = 0; k < 8 && mPhase != 1; k++) begin
            idleCycles(3, 1'b1);
            if (mPhase == 2) pulse(1'b0, 1'b1, 1'b1);
            else             pulse(1'b1, 1'b1, 1'b1);
        end
        idleCycles(4, 1'b1);
        pulse(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset from fault");
        doReset(3);

        $display("[TB] watchdog boundaries and display conversion");
        for (int k = 0; k < 3; k++) begin
            idleCycles(1022, 1'b0);
            pulse(1'b1, 1'b1, 1'b0);
        end
        idleCycles(1023, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd59, 7'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd120, 7'd99);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd100, 7'd127);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd9, 7'd10);
        idleCycles(1030, 1'b0);

        $display("[TB] final reset");
        doReset(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
